// File: rtl/passthrough_responder_pkg.sv
// Shared types and helpers for the passthrough CPU-interface responder.
// Holds the response-pipeline entry, latency bound and word-index helper.
package passthrough_responder_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int MAX_LATENCY    = 8;

  typedef struct packed {
    logic                      valid;
    logic                      is_wr;
    logic                      err;
    logic [DEF_DATA_WIDTH-1:0] data;
  } resp_entry_t;

  // Word index: drop the byte-lane bits, keep iw index bits.
  function automatic int unsigned word_idx(
    input logic [63:0] addr,
    input int unsigned wl,
    input int unsigned iw
  );
    logic [63:0] sh;
    sh = (addr >> wl) & ((64'd1 << iw) - 64'd1);
    return 32'(sh);
  endfunction

endpackage

// File: rtl/passthrough_responder_if.sv
// Passthrough CPU-interface bundle between an initiator and a responder.
// master = initiator side, slave = responder side.
interface passthrough_responder_if
  import passthrough_responder_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = 32
);

  logic                  s_cpuif_req;
  logic                  s_cpuif_req_is_wr;
  logic [ADDR_WIDTH-1:0] s_cpuif_addr;
  logic [DATA_WIDTH-1:0] s_cpuif_wr_data;
  logic                  s_cpuif_rd_ack;
  logic                  s_cpuif_rd_err;
  logic [DATA_WIDTH-1:0] s_cpuif_rd_data;
  logic                  s_cpuif_wr_ack;
  logic                  s_cpuif_wr_err;

  modport master (
    output s_cpuif_req, s_cpuif_req_is_wr,
    output s_cpuif_addr, s_cpuif_wr_data,
    input  s_cpuif_rd_ack, s_cpuif_rd_err,
    input  s_cpuif_rd_data,
    input  s_cpuif_wr_ack, s_cpuif_wr_err
  );

  modport slave (
    input  s_cpuif_req, s_cpuif_req_is_wr,
    input  s_cpuif_addr, s_cpuif_wr_data,
    output s_cpuif_rd_ack, s_cpuif_rd_err,
    output s_cpuif_rd_data,
    output s_cpuif_wr_ack, s_cpuif_wr_err
  );

endinterface

// File: rtl/passthrough_resp_pipe.sv
// Fixed-latency response shift register; stage 0 loads on accept.
// Reset flushes every stage to invalid so no stale ack escapes.
module passthrough_resp_pipe
  import passthrough_responder_pkg::*;
#(
  parameter int  LATENCY = 1,
  parameter type entry_t = resp_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  entry_t in_e,
  output entry_t out_e
);

  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_lat
    $error("LATENCY out of range");
  end

  entry_t stage_q [LATENCY];
  entry_t stage_d [LATENCY];

  // Shift every stage down by one, new entry enters stage 0.
  always_comb begin
    stage_d[0] = in_e;
    for (int i = 1; i < LATENCY; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Stage registers with flush-to-invalid on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign out_e = stage_q[LATENCY-1];

endmodule

// File: rtl/passthrough_responder.sv
// Passthrough CPU-interface responder: word memory, fixed-latency acks.
// Option macro: PASSTHROUGH_RESPONDER_ADDR_ERR_EN (out-of-range errors).
module passthrough_responder
  import passthrough_responder_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int LATENCY    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  passthrough_responder_if.slave  bus,
  output logic [15:0]             rd_count,
  output logic [15:0]             wr_count
);

  localparam int WL = $clog2(DATA_WIDTH / 8);
  localparam int IW = $clog2(DEPTH);
  localparam int HI = WL + IW;

  typedef struct packed {
    logic                  valid;
    logic                  is_wr;
    logic                  err;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  logic [IW-1:0]         idx;
  logic                  oor;
  logic                  rd_go;
  logic                  wr_go;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [15:0]           rd_count_q, rd_count_d;
  logic [15:0]           wr_count_q, wr_count_d;
  entry_t                req_e;
  entry_t                rsp_e;

  // Address decode: word index and optional range check.
  always_comb begin
    idx = IW'(word_idx(64'(bus.s_cpuif_addr), WL, IW));
    oor = 1'b0;
`ifdef PASSTHROUGH_RESPONDER_ADDR_ERR_EN
    if (HI < ADDR_WIDTH) begin
      oor = |(bus.s_cpuif_addr >> HI);
    end
`endif
    rd_go = bus.s_cpuif_req & ~bus.s_cpuif_req_is_wr;
    wr_go = bus.s_cpuif_req & bus.s_cpuif_req_is_wr;
  end

  // Memory write; out-of-range writes leave memory untouched.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_go && !oor) begin
      mem_d[idx] = bus.s_cpuif_wr_data;
    end
  end

  // Response entry: read data sampled from pre-write memory.
  always_comb begin
    req_e       = '0;
    req_e.valid = bus.s_cpuif_req;
    req_e.is_wr = bus.s_cpuif_req_is_wr;
    req_e.err   = bus.s_cpuif_req & oor;
    if (rd_go && !oor) begin
      req_e.data = mem_q[idx];
    end
  end

  // Saturating accept counters.
  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (rd_go && rd_count_q != 16'hFFFF) begin
      rd_count_d = rd_count_q + 16'd1;
    end
    if (wr_go && wr_count_q != 16'hFFFF) begin
      wr_count_d = wr_count_q + 16'd1;
    end
  end

  // Memory and counter state; reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  passthrough_resp_pipe #(
    .LATENCY (LATENCY),
    .entry_t (entry_t)
  ) u_pipe (
    .clk   (clk),
    .rst   (rst),
    .in_e  (req_e),
    .out_e (rsp_e)
  );

  // Output decode; read data is zero whenever there is no read ack.
  always_comb begin
    bus.s_cpuif_rd_ack  = rsp_e.valid & ~rsp_e.is_wr;
    bus.s_cpuif_wr_ack  = rsp_e.valid & rsp_e.is_wr;
    bus.s_cpuif_rd_err  = bus.s_cpuif_rd_ack & rsp_e.err;
    bus.s_cpuif_wr_err  = bus.s_cpuif_wr_ack & rsp_e.err;
    bus.s_cpuif_rd_data = '0;
    if (bus.s_cpuif_rd_ack) begin
      bus.s_cpuif_rd_data = rsp_e.data;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;

  a_req_known: assert property (
    @(posedge clk) disable iff (rst) !$isunknown(bus.s_cpuif_req)
  );

endmodule
